dm_access_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 (CPU MEM stage) and port 1 (peripheral/DMA master).
- Sequences each access as a multi-cycle transaction with fixed memory read latency.
- Generates store byte enables and aligned write data.
- For loads, presents the matching byte-select and load-extension control to the downstream load data-extension unit, time-aligned with mem_rdata.

---
 rtl/dm_access_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dm_access_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU MEM stage
// (port 0) and a peripheral/DMA master (port 1). Each access runs as a short
// transaction: IDLE (grant) -> ACCESS -> [WAIT] -> RESP -> IDLE.
module dm_access_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    input  logic        m0_unsigned,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    input  logic        m1_unsigned,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    output logic [1:0]  de_byteSel,
    output logic [2:0]  de_ctrl,
    output logic        rd_valid,
    output logic        rd_owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state;
    logic        prio;       // port preferred when both request
    logic        owner;
    logic        lt_we;
    logic        lt_uns;
    logic [1:0]  lt_size;
    logic [1:0]  lt_lsb;
    logic [2:0]  cnt;

    logic        grant;
    logic        sel;
    logic        s_we;
    logic        s_uns;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_size;
    logic        s_err;
    logic        load_fin;

    // Load-extension control code from access size and signedness
    function automatic logic [2:0] ext_ctrl(input logic [1:0] size, input logic uns);
        case (size)
            2'd0:    ext_ctrl = uns ? 3'd4 : 3'd2;
            2'd1:    ext_ctrl = uns ? 3'd3 : 3'd1;
            default: ext_ctrl = 3'd0;
        endcase
    endfunction

    // Arbitration, selected-port field mux, alignment check and load completion
    always_comb begin
        grant   = reset && (state == IDLE) && (m0_req || m1_req);
        sel     = (m0_req && m1_req) ? prio : m1_req;
        s_we    = sel ? m1_we       : m0_we;
        s_uns   = sel ? m1_unsigned : m0_unsigned;
        s_addr  = sel ? m1_addr     : m0_addr;
        s_wdata = sel ? m1_wdata    : m0_wdata;
        s_size  = sel ? m1_size     : m0_size;
        case (s_size)
            2'd0:    s_err = 1'b0;
            2'd1:    s_err = s_addr[0];
            2'd2:    s_err = |s_addr[1:0];
            default: s_err = 1'b1;
        endcase
        // A load finishes straight out of ACCESS when there is no WAIT phase,
        // otherwise on the last WAIT cycle, so RESP lands MEM_LAT after ACCESS.
        load_fin = ((state == ACCESS) && !lt_we && (MEM_LAT <= 1)) ||
                   ((state == WAIT) && (cnt == 3'd1));
    end

    assign m0_gnt = grant && !sel;
    assign m1_gnt = grant && sel;

    // Transaction FSM with registered memory, completion and extension outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            lt_we      <= 1'b0;
            lt_uns     <= 1'b0;
            lt_size    <= '0;
            lt_lsb     <= '0;
            cnt        <= '0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            rd_valid   <= 1'b0;
            rd_owner   <= 1'b0;
            de_byteSel <= '0;
            de_ctrl    <= '0;
        end else begin
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_byteen <= '0;
            mem_wdata  <= '0;
            rd_valid   <= 1'b0;
            rd_owner   <= 1'b0;
            de_byteSel <= '0;
            de_ctrl    <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        prio    <= !sel;
                        owner   <= sel;
                        lt_we   <= s_we;
                        lt_uns  <= s_uns;
                        lt_size <= s_size;
                        lt_lsb  <= s_addr[1:0];
                        if (s_err) begin
                            state   <= RESP;
                            m0_done <= !sel;
                            m1_done <= sel;
                            m0_err  <= !sel;
                            m1_err  <= sel;
                        end else begin
                            // Memory strobes are registered here so they are
                            // presented during the ACCESS cycle.
                            state    <= ACCESS;
                            mem_en   <= 1'b1;
                            mem_we   <= s_we;
                            mem_addr <= {s_addr[31:2], 2'b00};
                            if (s_we) begin
                                case (s_size)
                                    2'd0: begin
                                        mem_byteen <= 4'b0001 << s_addr[1:0];
                                        mem_wdata  <= {4{s_wdata[7:0]}};
                                    end
                                    2'd1: begin
                                        mem_byteen <= 4'b0011 << {s_addr[1], 1'b0};
                                        mem_wdata  <= {2{s_wdata[15:0]}};
                                    end
                                    default: begin
                                        mem_byteen <= 4'b1111;
                                        mem_wdata  <= s_wdata;
                                    end
                                endcase
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (lt_we) begin
                        state   <= RESP;
                        m0_done <= !owner;
                        m1_done <= owner;
                    end else if (!load_fin) begin
                        state <= WAIT;
                        cnt   <= 3'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (!load_fin) cnt <= cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
            if (load_fin) begin
                state      <= RESP;
                m0_done    <= !owner;
                m1_done    <= owner;
                rd_valid   <= 1'b1;
                rd_owner   <= owner;
                de_byteSel <= lt_lsb;
                de_ctrl    <= ext_ctrl(lt_size, lt_uns);
            end
        end
    end

endmodule
